thread_scheduler: RTL
=====================

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter THREAD_INDEX_BITS, default 3, thread index width; thread count NT = 2**THREAD_INDEX_BITS.
REQ-002 Parameter PIPE_DEPTH, default 7, minimum cycles between two issues of the same thread (fetch through write back).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 in_start_valid  input  1  request to start the thread named by in_start_thread_index.
REQ-006 in_start_thread_index  input  THREAD_INDEX_BITS  thread to start.
REQ-007 in_halt_valid  input  1  request to halt the thread named by in_halt_thread_index.
REQ-008 in_halt_thread_index  input  THREAD_INDEX_BITS  thread to halt.
REQ-009 in_stall  input  1  pipeline freeze; no issue while high.
REQ-010 out_issue_valid  output  1  registered; an instruction of out_thread_index is fetched this cycle.
REQ-011 out_thread_index  output  THREAD_INDEX_BITS  registered; thread index driven to pc_array and instruction memory address.
REQ-012 out_increment_flag  output  1  registered; equals out_issue_valid; drives pc_array increment.
REQ-013 out_active_mask  output  NT  registered; bit t = 1 when thread t is not IDLE.
REQ-014 out_idle  output  1  registered; 1 when every thread is IDLE.

Function
REQ-015 Each thread SHALL hold one state: IDLE, READY, COOLDOWN, DRAIN.
REQ-016 IDLE -> READY on start request for that thread; start to a non-IDLE thread SHALL be ignored.
REQ-017 READY -> COOLDOWN when the thread is issued; its cooldown counter loads PIPE_DEPTH-1.
REQ-018 COOLDOWN counter SHALL decrement by 1 per non-stalled cycle; at 0 with no halt the thread returns to READY on the next edge.
REQ-019 Halt of READY -> IDLE; halt of COOLDOWN -> DRAIN; DRAIN -> IDLE when counter reaches 0; halt to IDLE/DRAIN SHALL be ignored.
REQ-020 Start and halt for the same thread in the same cycle: halt SHALL win; start ignored.
REQ-021 Selection SHALL be round-robin: search begins at last issued index + 1 (mod NT) and takes the first READY thread.
REQ-022 Decision made from state at edge k SHALL appear on outputs after edge k (one-cycle registered latency); at most one issue per cycle.
REQ-023 No READY thread or in_stall = 1: out_issue_valid = 0, out_increment_flag = 0, out_thread_index holds its previous value.
REQ-024 While in_stall = 1, cooldown counters and round-robin pointer SHALL hold; start/halt requests SHALL still be applied.
REQ-025 A thread started in cycle k SHALL be eligible for selection at edge k+1 (earliest issue on outputs after edge k+2).
REQ-026 Round-robin pointer SHALL wrap from NT-1 to 0.

Reset
REQ-027 On reset = 0 at a rising edge: all threads IDLE, counters 0, pointer NT-1, out_issue_valid 0, out_increment_flag 0, out_thread_index 0, out_active_mask 0, out_idle 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight cooldown/drain state in that cycle.

Configuration
REQ-029 Macro THREAD_SCHED_HAZARD_GUARD_EN: defined -> COOLDOWN/DRAIN and counters as above; undefined -> issued thread returns to READY directly, halt of any non-IDLE thread goes to IDLE, no counters synthesized.

Structure
REQ-030 Shared package SHALL hold the thread-state enum (IDLE, READY, COOLDOWN, DRAIN) and the cooldown counter width constant $clog2(PIPE_DEPTH).
REQ-031 One sub-module rr_arbiter (NT request bits, pointer in, grant index and grant valid out, combinational) SHALL implement REQ-021.

Verification
REQ-032 Reset, start thread 0 only, guard on -> issues of thread 0 exactly every 7 cycles; out_active_mask = 0x01.
REQ-033 Start all 8 threads same cycle sequentially -> issue order 0,1,...,7,0 with out_issue_valid continuously 1.
REQ-034 Threads 2 and 5 running, in_stall high 3 cycles -> no issue for 3 cycles, then order resumes 2/5 alternation from the held pointer.
REQ-035 Halt thread 3 one cycle after its issue -> mask bit 3 stays 1 for 6 more cycles (DRAIN), then 0; no further thread-3 issue.
REQ-036 Simultaneous start and halt of thread 4 while IDLE -> thread 4 stays IDLE, out_idle stays 1.
REQ-037 Reset asserted while threads 1 and 6 in COOLDOWN -> next cycle all outputs at reset values; guard off build -> thread 0 alone issues every cycle.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// Shared definitions for the thread scheduler.
// Holds the per-thread state encoding and the cooldown counter sizing.
package thread_scheduler_pkg;

  typedef enum logic [1:0] {
    TS_IDLE     = 2'd0,
    TS_READY    = 2'd1,
    TS_COOLDOWN = 2'd2,
    TS_DRAIN    = 2'd3
  } thread_state_e;

  localparam int DEFAULT_PIPE_DEPTH = 7;

  // Counter width for a given pipeline depth; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_PIPE_DEPTH);

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Round-robin arbiter (combinational).
// Ports:
//   req_i         one request bit per thread
//   ptr_i         index of the last granted thread; search starts at ptr_i+1
//   grant_idx_o   first requesting index found (ptr_i when nothing requests)
//   grant_valid_o at least one request present
module rr_arbiter #(
  parameter int IDX_BITS = 3
) (
  input  logic [(2**IDX_BITS)-1:0] req_i,
  input  logic [IDX_BITS-1:0]      ptr_i,
  output logic [IDX_BITS-1:0]      grant_idx_o,
  output logic                     grant_valid_o
);

  localparam int N = 2**IDX_BITS;

  logic [IDX_BITS-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest request after
  // the pointer is the one left standing; index arithmetic wraps mod N.
  always_comb begin
    grant_idx_o   = ptr_i;
    grant_valid_o = 1'b0;
    idx_s         = ptr_i;
    for (int i = N; i >= 1; i--) begin
      idx_s         = ptr_i + IDX_BITS'(i);
      grant_idx_o   = req_i[idx_s] ? idx_s : grant_idx_o;
      grant_valid_o = grant_valid_o | req_i[idx_s];
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-style thread scheduler: picks at most one READY thread per cycle
// in round-robin order and enforces a minimum re-issue distance.
// Config macro: THREAD_SCHED_HAZARD_GUARD_EN enables COOLDOWN/DRAIN states
// and per-thread counters; without it an issued thread stays READY.
// Ports:
//   clk, reset (sync, active-low)
//   in_start_valid/in_start_thread_index  start an IDLE thread
//   in_halt_valid/in_halt_thread_index    halt a thread (wins over start)
//   in_stall                              freeze issue, counters and pointer
//   out_issue_valid, out_thread_index, out_increment_flag  issue result
//   out_active_mask, out_idle             thread occupancy status
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int THREAD_INDEX_BITS = 3,
  parameter int PIPE_DEPTH        = DEFAULT_PIPE_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_start_valid,
  input  logic [THREAD_INDEX_BITS-1:0]   in_start_thread_index,
  input  logic                           in_halt_valid,
  input  logic [THREAD_INDEX_BITS-1:0]   in_halt_thread_index,
  input  logic                           in_stall,
  output logic                           out_issue_valid,
  output logic [THREAD_INDEX_BITS-1:0]   out_thread_index,
  output logic                           out_increment_flag,
  output logic [(2**THREAD_INDEX_BITS)-1:0] out_active_mask,
  output logic                           out_idle
);

  localparam int IW = THREAD_INDEX_BITS;
  localparam int NT = 2**THREAD_INDEX_BITS;
`ifdef THREAD_SCHED_HAZARD_GUARD_EN
  localparam int CW = cnt_width(PIPE_DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PIPE_DEPTH - 1);

  logic [CW-1:0] cnt_q [NT];
  logic [CW-1:0] cnt_d [NT];
`endif

  thread_state_e state_q [NT];
  thread_state_e state_d [NT];
  logic [IW-1:0] ptr_q, ptr_d;
  logic [NT-1:0] req_s, start_s, halt_s;
  logic [IW-1:0] grant_idx_s;
  logic          grant_valid_s, issue_s;

  logic          issue_valid_q, issue_valid_d;
  logic [IW-1:0] thread_index_q, thread_index_d;
  logic [NT-1:0] active_mask_q, active_mask_d;
  logic          idle_q, idle_d;

  rr_arbiter #(.IDX_BITS(IW)) u_rr_arbiter (
    .req_i         (req_s),
    .ptr_i         (ptr_q),
    .grant_idx_o   (grant_idx_s),
    .grant_valid_o (grant_valid_s)
  );

  // Per-thread request decode; halt masks a same-cycle start.
  always_comb begin
    req_s   = '0;
    halt_s  = '0;
    start_s = '0;
    for (int t = 0; t < NT; t++) begin
      req_s[t]   = (state_q[t] == TS_READY);
      halt_s[t]  = in_halt_valid & (in_halt_thread_index == IW'(t));
      start_s[t] = in_start_valid & (in_start_thread_index == IW'(t)) & ~halt_s[t];
    end
  end

  assign issue_s = grant_valid_s & ~in_stall;

  // Thread state machines and issue/status next values.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      state_d[t] = state_q[t];
`ifdef THREAD_SCHED_HAZARD_GUARD_EN
      cnt_d[t]   = cnt_q[t];
`endif
      case (state_q[t])
        TS_IDLE: begin
          if (start_s[t]) state_d[t] = TS_READY;
          else            state_d[t] = TS_IDLE;
        end
        TS_READY: begin
          if (halt_s[t]) begin
            state_d[t] = TS_IDLE;
          end else if (issue_s && (grant_idx_s == IW'(t))) begin
`ifdef THREAD_SCHED_HAZARD_GUARD_EN
            state_d[t] = TS_COOLDOWN;
            cnt_d[t]   = CNT_LOAD;
`else
            state_d[t] = TS_READY;
`endif
          end else begin
            state_d[t] = TS_READY;
          end
        end
`ifdef THREAD_SCHED_HAZARD_GUARD_EN
        // The decrement that reaches zero also releases the thread, so the
        // same thread re-issues exactly PIPE_DEPTH unstalled cycles later.
        TS_COOLDOWN: begin
          if (!in_stall) begin
            cnt_d[t] = cnt_q[t] - CW'(1);
            if (cnt_q[t] <= CW'(1)) state_d[t] = halt_s[t] ? TS_IDLE : TS_READY;
            else                    state_d[t] = halt_s[t] ? TS_DRAIN : TS_COOLDOWN;
          end else begin
            state_d[t] = halt_s[t] ? TS_DRAIN : TS_COOLDOWN;
          end
        end
        TS_DRAIN: begin
          if (!in_stall) begin
            cnt_d[t] = cnt_q[t] - CW'(1);
            if (cnt_q[t] <= CW'(1)) state_d[t] = TS_IDLE;
            else                    state_d[t] = TS_DRAIN;
          end else begin
            state_d[t] = TS_DRAIN;
          end
        end
`endif
        default: state_d[t] = TS_IDLE;
      endcase
    end

    issue_valid_d  = issue_s;
    thread_index_d = issue_s ? grant_idx_s : thread_index_q;
    ptr_d          = issue_s ? grant_idx_s : ptr_q;
    active_mask_d  = '0;
    for (int t = 0; t < NT; t++) begin
      active_mask_d[t] = (state_d[t] != TS_IDLE);
    end
    idle_d = ~|active_mask_d;
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int t = 0; t < NT; t++) begin
        state_q[t] <= TS_IDLE;
`ifdef THREAD_SCHED_HAZARD_GUARD_EN
        cnt_q[t]   <= '0;
`endif
      end
      ptr_q          <= IW'(NT - 1);
      issue_valid_q  <= 1'b0;
      thread_index_q <= '0;
      active_mask_q  <= '0;
      idle_q         <= 1'b1;
    end else begin
      for (int t = 0; t < NT; t++) begin
        state_q[t] <= state_d[t];
`ifdef THREAD_SCHED_HAZARD_GUARD_EN
        cnt_q[t]   <= cnt_d[t];
`endif
      end
      ptr_q          <= ptr_d;
      issue_valid_q  <= issue_valid_d;
      thread_index_q <= thread_index_d;
      active_mask_q  <= active_mask_d;
      idle_q         <= idle_d;
    end
  end

  assign out_issue_valid    = issue_valid_q;
  assign out_increment_flag = issue_valid_q;
  assign out_thread_index   = thread_index_q;
  assign out_active_mask    = active_mask_q;
  assign out_idle           = idle_q;

endmodule
